// File: rtl/odelay_dyn_if.sv
// -----------------------------------------------------------------------------
// odelay_dyn_if
// Signal bundle between the TX output register / calibration logic and the
// dynamic output delay element.
//   a         : pad-bound data to be delayed          (master -> slave)
//   loadn     : active-low reload of tap to DEL_VALUE (master -> slave)
//   move      : tap step request, rising edge acts    (master -> slave)
//   direction : 0 = add delay, 1 = remove delay       (master -> slave)
//   z         : delayed data                          (slave -> master)
//   cflag     : last step request hit a tap limit     (slave -> master)
//   tap       : current tap value                     (slave -> master)
// -----------------------------------------------------------------------------
interface odelay_dyn_if #(
   parameter int TAP_BITS = 7
);
   logic                a;
   logic                loadn;
   logic                move;
   logic                direction;
   logic                z;
   logic                cflag;
   logic [TAP_BITS-1:0] tap;

   modport master (
      output a, loadn, move, direction,
      input  z, cflag, tap
   );

   modport slave (
      input  a, loadn, move, direction,
      output z, cflag, tap
   );
endinterface

// File: rtl/odelay_dyn.sv
// -----------------------------------------------------------------------------
// odelay_dyn
// Run-time adjustable output delay element (DELAYF-style tap control).
// The input is shifted through a 2^TAP_BITS deep history line and the output
// register picks the entry selected by the current tap, giving a latency of
// tap+1 clock cycles.
// Ports:
//   sclk_i : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset
//   bus    : odelay_dyn_if slave modport (a/loadn/move/direction in,
//            z/cflag/tap out)
// -----------------------------------------------------------------------------
module odelay_dyn #(
   parameter int TAP_BITS  = 7,
   parameter int DEL_VALUE = 0,
   parameter     DEL_MODE  = "USER_DEFINED"
) (
   input  logic          sclk_i,
   input  logic          rst_i,
   odelay_dyn_if.slave   bus
);

   localparam int                  DEPTH    = 32'd1 << TAP_BITS;
   localparam logic [TAP_BITS-1:0] TAP_INIT = TAP_BITS'(DEL_VALUE);
   localparam logic [TAP_BITS-1:0] TAP_MAX  = {TAP_BITS{1'b1}};
   localparam logic [TAP_BITS-1:0] TAP_MIN  = {TAP_BITS{1'b0}};
   localparam logic [TAP_BITS-1:0] TAP_ONE  = {{(TAP_BITS-1){1'b0}}, 1'b1};

   logic [DEPTH-1:0]    sr_q;
   logic [DEPTH-1:0]    sr_d;
   logic [TAP_BITS-1:0] tap_q;
   logic [TAP_BITS-1:0] tap_d;
   logic                cflag_q;
   logic                cflag_d;
   logic                z_q;
   logic                z_d;
   logic                move_q;
   logic                step_s;

   // Tap/flag next state: reload beats a step, a step saturates instead of wrapping.
   always_comb begin
      tap_d   = tap_q;
      cflag_d = cflag_q;
      step_s  = bus.move & ~move_q;
      if (!bus.loadn) begin
         // A MOVE edge coinciding with the load is dropped on purpose.
         tap_d   = TAP_INIT;
         cflag_d = 1'b0;
      end else if (step_s) begin
         if (!bus.direction) begin
            if (tap_q == TAP_MAX) begin
               cflag_d = 1'b1;
            end else begin
               tap_d   = tap_q + TAP_ONE;
               cflag_d = 1'b0;
            end
         end else begin
            if (tap_q == TAP_MIN) begin
               cflag_d = 1'b1;
            end else begin
               tap_d   = tap_q - TAP_ONE;
               cflag_d = 1'b0;
            end
         end
      end else begin
         tap_d   = tap_q;
         cflag_d = cflag_q;
      end
   end

   // History line shift and output tap selection (uses the tap in force before this edge).
   always_comb begin
      sr_d = {sr_q[DEPTH-2:0], bus.a};
      z_d  = sr_q[tap_q];
   end

   // State registers; reset clears history so no pre-reset data can reach the pad.
   always_ff @(posedge sclk_i) begin
      if (rst_i) begin
         sr_q    <= {DEPTH{1'b0}};
         tap_q   <= TAP_INIT;
         cflag_q <= 1'b0;
         z_q     <= 1'b0;
         move_q  <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         tap_q   <= tap_d;
         cflag_q <= cflag_d;
         z_q     <= z_d;
         // Tracked during load as well, so MOVE held across a load release cannot step.
         move_q  <= bus.move;
      end
   end

   assign bus.z     = z_q;
   assign bus.cflag = cflag_q;
   assign bus.tap   = tap_q;

endmodule

// File: tb/tb_odelay_dyn.sv
// -----------------------------------------------------------------------------
// tb_odelay_dyn
// Two instances (DEL_VALUE = 0 and DEL_VALUE = 5) share one stimulus stream.
// A driver issues directed and random cycles and pushes the predicted outputs
// of both instances into a scoreboard queue; a monitor pops one entry per
// cycle and compares. The reference keeps the whole sampled input history and
// derives Z as "the sample taken tap+1 edges ago, unless a reset came since".
// -----------------------------------------------------------------------------
module tb_odelay_dyn;

   localparam int TB = 7;
   localparam int TMAX = (1 << TB) - 1;

   typedef struct {
      bit z [2];
      bit c [2];
      int t [2];
   } exp_t;

   logic clk;
   logic rst;

   odelay_dyn_if #(.TAP_BITS(TB)) bus0 ();
   odelay_dyn_if #(.TAP_BITS(TB)) bus5 ();

   odelay_dyn #(.TAP_BITS(TB), .DEL_VALUE(0), .DEL_MODE("USER_DEFINED")) u_dut0 (
      .sclk_i (clk),
      .rst_i  (rst),
      .bus    (bus0.slave)
   );

   odelay_dyn #(.TAP_BITS(TB), .DEL_VALUE(5), .DEL_MODE("USER_DEFINED")) u_dut5 (
      .sclk_i (clk),
      .rst_i  (rst),
      .bus    (bus5.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model state, index 0 -> u_dut0, index 1 -> u_dut5
   int   del_v [2] = '{0, 5};
   int   m_tap [2];
   bit   m_cf  [2];
   bit   m_prev[2];
   bit   samp [$];
   int   last_rst = -1;
   exp_t sb [$];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   // one clock cycle of stimulus plus the predicted result after the edge
   task automatic cyc(input bit r, input bit av, input bit ln, input bit mv, input bit dr);
      exp_t e;
      int   eidx;
      int   src;
      @(posedge clk);
      #2;
      rst = r;
      bus0.a = av; bus0.loadn = ln; bus0.move = mv; bus0.direction = dr;
      bus5.a = av; bus5.loadn = ln; bus5.move = mv; bus5.direction = dr;
      eidx = samp.size();
      for (int k = 0; k < 2; k++) begin
         if (r) begin
            e.z[k]    = 1'b0;
            m_tap[k]  = del_v[k];
            m_cf[k]   = 1'b0;
            m_prev[k] = 1'b0;
         end else begin
            src = eidx - 1 - m_tap[k];
            e.z[k] = (src >= 0 && src > last_rst) ? samp[src] : 1'b0;
            if (!ln) begin
               m_tap[k] = del_v[k];
               m_cf[k]  = 1'b0;
            end else if (mv && !m_prev[k]) begin
               if (!dr) begin
                  if (m_tap[k] < TMAX) begin m_tap[k]++; m_cf[k] = 1'b0; end
                  else m_cf[k] = 1'b1;
               end else begin
                  if (m_tap[k] > 0) begin m_tap[k]--; m_cf[k] = 1'b0; end
                  else m_cf[k] = 1'b1;
               end
            end
            m_prev[k] = mv;
         end
         e.c[k] = m_cf[k];
         e.t[k] = m_tap[k];
      end
      sb.push_back(e);
      samp.push_back(r ? 1'b0 : av);
      if (r) last_rst = eidx;
   endtask

   task automatic idle(input int n, input bit av);
      for (int i = 0; i < n; i++) cyc(1'b0, av, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic pulse(input bit dr);
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, dr);
      cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0, dr);
   endtask

   // monitor: outputs are valid every cycle, compare one entry shortly after each edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("z_del0",     int'(bus0.z),     int'(e.z[0]));
            chk("cflag_del0", int'(bus0.cflag), int'(e.c[0]));
            chk("tap_del0",   int'(bus0.tap),   e.t[0]);
            chk("z_del5",     int'(bus5.z),     int'(e.z[1]));
            chk("cflag_del5", int'(bus5.cflag), int'(e.c[1]));
            chk("tap_del5",   int'(bus5.tap),   e.t[1]);
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus0.a = 1'b1; bus0.loadn = 1'b1; bus0.move = 1'b0; bus0.direction = 1'b0;
      bus5.a = 1'b1; bus5.loadn = 1'b1; bus5.move = 1'b0; bus5.direction = 1'b0;

      // reset with A high, then a single A pulse through tap 5
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(3, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(10, 1'b0);

      // three up steps, then MOVE held high for 10 cycles (one step only)
      for (int i = 0; i < 3; i++) pulse(1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(12, 1'b0);

      // walk down to 1, then saturate at 0 and come back up
      for (int i = 0; i < 8; i++) pulse(1'b1);
      pulse(1'b1);
      pulse(1'b1);
      pulse(1'b0);

      // walk up into the top limit
      for (int i = 0; i < TMAX + 2; i++) pulse(1'b0);

      // load with a coincident MOVE rise, then MOVE still high after release
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // tap 40, constant A = 1, reset mid-stream
      for (int i = 0; i < 35; i++) pulse(1'b0);
      idle(50, 1'b1);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(20, 1'b1);

      // A toggling every cycle (tap 0 instance is a plain one-cycle register)
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'(i % 2), 1'b1, 1'b0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 29) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      end

      @(posedge clk);
      #3;
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/odelay_dyn.md
# odelay_dyn

Dynamically adjustable output delay element for the ASIC mapping of the Ethernet PHY pads, and the transmit-side counterpart of the fixed input delay on the receive path. It delays a single-bit pad-bound signal by a run-time selectable number of clock cycles, from 0 to 2^TAP_BITS−1 taps plus one register stage. The tap is moved with the Lattice DELAYF-style LOADN/MOVE/DIRECTION/CFLAG controls, so soft-core delay calibration logic drives it unchanged. The block sits between the TX output register and the pad buffer.

## Interface
- TAP_BITS, 7: tap counter width; delay line depth is 2^TAP_BITS stages (default 128).
- DEL_VALUE, 0: tap loaded at reset and on LOADN; legal range 0..2^TAP_BITS−1.
- DEL_MODE, "USER_DEFINED": accepted for primitive compatibility; no functional effect.
- SCLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- A  in  1  data to delay.
- LOADN  in  1  active-low reload of tap to DEL_VALUE.
- MOVE  in  1  step request; acts on rising edge only.
- DIRECTION  in  1  0 = increase delay (tap+1), 1 = decrease delay (tap−1).
- Z  out  1  delayed data.
- CFLAG  out  1  saturation flag: last step request hit a tap limit.
- TAP  out  TAP_BITS  current tap value.

## Operation
- Delay line: sr[0] <= A; sr[i] <= sr[i−1] for i = 1..2^TAP_BITS−1; Z <= sr[TAP] on every edge.
- Per-edge priority: RST, then LOADN = 0, then a MOVE step.
- RST = 1: TAP = DEL_VALUE, sr all 0, Z = 0, CFLAG = 0, move_q = 0.
- LOADN = 0 (no RST): TAP = DEL_VALUE, CFLAG = 0. A coincident MOVE edge is discarded.
- MOVE edge detect: move_q <= MOVE on every non-reset edge, including while LOADN = 0. A step fires when MOVE = 1 and move_q = 0.
- MOVE held high produces exactly one step. MOVE already high when LOADN releases produces no step.
- Step with DIRECTION = 0:
  - TAP < max: TAP+1, CFLAG = 0.
  - TAP = max: TAP holds, CFLAG = 1.
- Step with DIRECTION = 1:
  - TAP > 0: TAP−1, CFLAG = 0.
  - TAP = 0: TAP holds, CFLAG = 1.
- CFLAG is sticky. It changes only on a step, a load, or reset.
- No wrap-around of TAP in either direction.
- sr contents are never cleared except by RST, so a tap change selects already-shifted history immediately. Glitches on Z at a tap change are permitted and are the caller's concern.

## Timing
- Latency A to Z: TAP+1 cycles. A sampled at edge k appears on Z after edge k+TAP+1. TAP = 0 gives a one-register delay.
- New TAP is visible on the TAP output the edge after the MOVE rise or LOADN low is sampled. It selects Z from the following edge.
- CFLAG updates on the same edge as TAP.
- After RST deasserts, Z = 0 for at least TAP+1 cycles regardless of A before reset.
- RST asserted mid-stream takes effect on the next edge, discarding all in-flight data and any pending step.

## Test plan
- Reset/latency, DEL_VALUE = 5: after RST, TAP = 5, Z = 0, CFLAG = 0. One-cycle A pulse sampled at edge k → Z = 1 only after edge k+6.
- Stepping: from TAP = 5, three MOVE pulses with DIRECTION = 0 → TAP = 8. Then MOVE held high 10 cycles → TAP = 9 only. Then a 1-cycle A pulse → Z delayed 10 cycles.
- Saturation low/high:
  - From TAP = 1, two DIRECTION = 1 pulses → TAP = 0, CFLAG = 1 after the second. One DIRECTION = 0 pulse → TAP = 1, CFLAG = 0.
  - At TAP = 127, a DIRECTION = 0 pulse → TAP = 127, CFLAG = 1.
- Load priority: TAP = 20, CFLAG = 1. LOADN = 0 on the same edge as a MOVE rise → TAP = DEL_VALUE, CFLAG = 0, no step. MOVE still high when LOADN = 1 → no step.
- Reset mid-operation: A = 1 constant, TAP = 40. Assert RST one cycle → next edge Z = 0, TAP = DEL_VALUE, CFLAG = 0. With A held at 1, Z stays 0 for DEL_VALUE+1 cycles after release, then 1.
- Tap 0 passthrough: DEL_VALUE = 0, A toggling every cycle → Z equals A delayed exactly one cycle.
